// File: rtl/ex_mdu.sv
// rtl/ex_mdu.sv - EX-stage iterative multiply/divide unit owning HI/LO
// Multiply waits a fixed number of cycles; divide is radix-2 restoring on operand magnitudes.
module ex_mdu #(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        ex_hold,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MCW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [MCW-1:0] MC_LAST = MCW'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t          r_state;
  logic [4:0]      r_cnt;
  logic [MCW-1:0]  r_mcnt;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic [31:0]     r_rem;
  logic            r_signed;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [31:0]     r_hi;
  logic [31:0]     r_lo;

  logic            w_sgn;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [31:0]     w_a_mag;
  logic [31:0]     w_b_mag;
  logic [63:0]     w_ax;
  logic [63:0]     w_bx;
  logic [63:0]     w_prod;
  logic [32:0]     w_sh;
  logic            w_ge;
  logic [31:0]     w_diff;
  logic [31:0]     w_rem_n;
  logic [31:0]     w_quo_n;
  logic [31:0]     w_q_fix;
  logic [31:0]     w_r_fix;

  // op 0 (MULT) and op 2 (DIV) are the signed variants
  assign w_sgn   = ~op[0];
  assign w_a_neg = w_sgn & src_a[31];
  assign w_b_neg = w_sgn & src_b[31];
  assign w_a_mag = w_a_neg ? (32'd0 - src_a) : src_a;
  assign w_b_mag = w_b_neg ? (32'd0 - src_b) : src_b;

  assign w_ax   = {{32{r_signed & r_a[31]}}, r_a};
  assign w_bx   = {{32{r_signed & r_b[31]}}, r_b};
  assign w_prod = w_ax * w_bx;

  // r_a holds the dividend shifting out MSB-first while quotient bits shift in
  assign w_sh    = {r_rem, r_a[31]};
  assign w_ge    = (w_sh >= {1'b0, r_b});
  assign w_diff  = w_sh[31:0] - r_b;
  assign w_rem_n = w_ge ? w_diff : w_sh[31:0];
  assign w_quo_n = {r_a[30:0], w_ge};
  assign w_q_fix = r_neg_q ? (32'd0 - w_quo_n) : w_quo_n;
  assign w_r_fix = r_neg_r ? (32'd0 - w_rem_n) : w_rem_n;

  assign busy = ~flush & ((r_state == S_MUL) | (r_state == S_DIV) |
                          ((r_state == S_IDLE) & start & ~op[2]));
  assign done = (r_state == S_DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_mcnt   <= '0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_rem    <= 32'd0;
      r_signed <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_mcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (!op[2]) begin
              r_cnt    <= 5'd0;
              r_mcnt   <= '0;
              r_rem    <= 32'd0;
              r_signed <= w_sgn;
              r_neg_q  <= w_a_neg ^ w_b_neg;
              r_neg_r  <= w_a_neg;
              if (!op[1]) begin
                r_a     <= src_a;
                r_b     <= src_b;
                r_state <= S_MUL;
              end else if (src_b == 32'd0) begin
                r_a     <= src_a;
                r_b     <= src_b;
                r_hi    <= src_a;
                r_lo    <= 32'hFFFF_FFFF;
                r_state <= S_DONE;
              end else begin
                r_a     <= w_a_mag;
                r_b     <= w_b_mag;
                r_state <= S_DIV;
              end
            end else if (op == 3'd4) begin
              r_hi <= src_a;
            end else if (op == 3'd5) begin
              r_lo <= src_a;
            end
          end
        end
        S_MUL: begin
          if (r_mcnt == MC_LAST) begin
            r_hi    <= w_prod[63:32];
            r_lo    <= w_prod[31:0];
            r_mcnt  <= '0;
            r_state <= S_DONE;
          end else begin
            r_mcnt <= r_mcnt + MCW'(1);
          end
        end
        S_DIV: begin
          r_a   <= w_quo_n;
          r_rem <= w_rem_n;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_hi    <= w_r_fix;
            r_lo    <= w_q_fix;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!ex_hold) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// tb/tb_ex_mdu.sv - directed self-checking bench for ex_mdu
module tb_ex_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        ex_hold;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_errors = 0;

  ex_mdu #(.MUL_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .ex_hold(ex_hold), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one mul/div op and follow it until done, counting busy cycles.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cyc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int nb;
    int cyc;
    tick();
    start = 1'b1; op = o; src_a = a; src_b = b;
    nb = 0; cyc = 0;
    #1;
    while (!done && cyc < 100) begin
      if (busy) nb++;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
      #1;
    end
    check({tag, ".done_cyc"}, 64'(cyc), 64'(exp_cyc));
    check({tag, ".busy_cyc"}, 64'(nb), 64'(exp_cyc));
    check({tag, ".hi"}, 64'(hi), 64'(exp_hi));
    check({tag, ".lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    int dcnt;
    rst = 1'b1; start = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0;
    flush = 1'b0; ex_hold = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.hi", 64'(hi), 64'd0);
    check("rst.lo", 64'(lo), 64'd0);

    run_op("mult",   3'd0, 32'hFFFF_FFFD, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu",  3'd1, 32'hFFFF_FFFD, 32'd7, 5, 32'h0000_0006, 32'hFFFF_FFEB);
    run_op("mult_min", 3'd0, 32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'h0);
    run_op("divu",   3'd3, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negb", 3'd2, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
    run_op("divu_max", 3'd3, 32'hFFFF_FFFF, 32'd1, 33, 32'd0, 32'hFFFF_FFFF);
    run_op("divu_z", 3'd3, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF);

    // reset in the middle of a divide
    tick();
    start = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd7;
    tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_mid.busy", 64'(busy), 64'd0);
    check("rst_mid.done", 64'(done), 64'd0);
    check("rst_mid.hi", 64'(hi), 64'd0);
    check("rst_mid.lo", 64'(lo), 64'd0);

    // MTHI then MTLO
    tick();
    start = 1'b1; op = 3'd4; src_a = 32'hDEAD_BEEF;
    #1;
    check("mthi.busy", 64'(busy), 64'd0);
    tick();
    op = 3'd5; src_a = 32'h1234_5678;
    #1;
    check("mthi.hi", 64'(hi), 64'hDEAD_BEEF);
    check("mtlo.busy", 64'(busy), 64'd0);
    check("mthi.done", 64'(done), 64'd0);
    tick();
    op = 3'd6; src_a = 32'hAAAA_AAAA;
    #1;
    check("mtlo.lo", 64'(lo), 64'h1234_5678);
    check("mtlo.hi", 64'(hi), 64'hDEAD_BEEF);
    check("op6.busy", 64'(busy), 64'd0);
    tick();
    start = 1'b0;
    #1;
    check("op6.hi", 64'(hi), 64'hDEAD_BEEF);
    check("op6.lo", 64'(lo), 64'h1234_5678);

    // flush at cycle 10 of a divide
    tick();
    start = 1'b1; op = 3'd4; src_a = 32'h11;
    tick();
    op = 3'd5; src_a = 32'h22;
    tick();
    op = 3'd3; src_a = 32'd100; src_b = 32'd7;
    for (int i = 1; i < 10; i++) begin
      tick();
      start = 1'b0;
    end
    tick();
    flush = 1'b1;
    #1;
    check("flush.busy_in", 64'(busy), 64'd0);
    tick();
    flush = 1'b0;
    #1;
    check("flush.busy_after", 64'(busy), 64'd0);
    check("flush.hi", 64'(hi), 64'h11);
    check("flush.lo", 64'(lo), 64'h22);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dcnt++;
      tick();
    end
    check("flush.no_done", 64'(dcnt), 64'd0);
    check("flush.hi_late", 64'(hi), 64'h11);

    // flush coinciding with the final MUL edge
    start = 1'b1; op = 3'd0; src_a = 32'd3; src_b = 32'd5;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flush_mul.done", 64'(done), 64'd0);
    check("flush_mul.hi", 64'(hi), 64'h11);
    check("flush_mul.lo", 64'(lo), 64'h22);

    // ex_hold in DONE with start held; changed src_a would show a re-accept
    tick();
    start = 1'b1; op = 3'd2; src_a = 32'd5; src_b = 32'd0;
    dcnt = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      ex_hold = 1'b1; src_a = 32'h99;
      #1;
      if (done) dcnt++;
      check("hold.busy", 64'(busy), 64'd0);
    end
    tick();
    ex_hold = 1'b0;
    #1;
    if (done) dcnt++;
    check("hold.hi", 64'(hi), 64'd5);
    tick();
    start = 1'b0;
    #1;
    if (done) dcnt++;
    check("hold.done_cycles", 64'(dcnt), 64'd4);
    check("hold.idle_done", 64'(done), 64'd0);
    check("hold.hi_final", 64'(hi), 64'd5);
    check("hold.lo_final", 64'(lo), 64'hFFFF_FFFF);

    // back-to-back op directly after a hold
    run_op("after_hold", 3'd1, 32'd6, 32'd7, 5, 32'd0, 32'd42);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
